// File: rtl/degamma_lut.sv
// degamma_lut -- inverse-gamma (linearisation) stage at the front of the ISP pipeline.
//
// Maps gamma-encoded samples back to linear through a 2^COLOR_DEPTH-entry LUT.
// The LUT is double-buffered:
//   - Software writes the shadow bank.
//   - A commit swaps banks at a picture boundary.
//   - The new active bank is then copied back into the shadow, one entry per cycle,
//     so the next round of edits starts from what is currently live.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pixel_in            gamma-encoded sample
//   valid_in            qualifies pixel_in / color_in / last_pic_in
//   color_in            CFA color tag, carried alongside the pixel
//   last_pic_in         last pixel of the picture (qualified by valid_in)
//   cfg_wr_en           shadow-bank write strobe
//   cfg_addr, cfg_data  shadow entry index and value
//   cfg_commit          one-cycle pulse requesting a bank swap
//   cfg_busy            high while a swap is pending or the copy-back runs;
//                       writes and commits are dropped while high
//   pixel_out           linearised sample, 2 cycles after pixel_in
//   valid_out, color_out, last_pic_out
//                       sideband, delayed by the same 2 cycles
module degamma_lut #(
    parameter int COLOR_DEPTH = 8,
    parameter int COLOR_BITS  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [COLOR_DEPTH-1:0] pixel_in,
    input  logic                   valid_in,
    input  logic [COLOR_BITS-1:0]  color_in,
    input  logic                   last_pic_in,
    input  logic                   cfg_wr_en,
    input  logic [COLOR_DEPTH-1:0] cfg_addr,
    input  logic [COLOR_DEPTH-1:0] cfg_data,
    input  logic                   cfg_commit,
    output logic                   cfg_busy,
    output logic [COLOR_DEPTH-1:0] pixel_out,
    output logic                   valid_out,
    output logic [COLOR_BITS-1:0]  color_out,
    output logic                   last_pic_out
);

    localparam int LUT_SIZE = 1 << COLOR_DEPTH;
    localparam logic [COLOR_DEPTH-1:0] IDX_ZERO = {COLOR_DEPTH{1'b0}};
    localparam logic [COLOR_DEPTH-1:0] IDX_ONE  = {{(COLOR_DEPTH-1){1'b0}}, 1'b1};
    localparam logic [COLOR_DEPTH-1:0] IDX_LAST = {COLOR_DEPTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COPY    = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   bank_sel_r;
    logic                   in_pic_r;
    logic [COLOR_DEPTH-1:0] copy_cnt_r;

    logic [COLOR_DEPTH-1:0] bank0_r [LUT_SIZE];
    logic [COLOR_DEPTH-1:0] bank1_r [LUT_SIZE];

    logic [COLOR_DEPTH-1:0] pix1_r;
    logic                   vld1_r;
    logic [COLOR_BITS-1:0]  col1_r;
    logic                   last1_r;

    logic [COLOR_DEPTH-1:0] lut_out_s;
    logic [COLOR_DEPTH-1:0] copy_data_s;
    logic                   swap_s;
    logic                   shadow_we_s;
    logic [COLOR_DEPTH-1:0] shadow_addr_s;
    logic [COLOR_DEPTH-1:0] shadow_data_s;

    // Read ports of the active bank: one for the pixel lookup, one for the copy-back.
    always_comb begin
        lut_out_s   = {COLOR_DEPTH{1'b0}};
        copy_data_s = {COLOR_DEPTH{1'b0}};
        if (bank_sel_r) begin
            lut_out_s   = bank1_r[pix1_r];
            copy_data_s = bank1_r[copy_cnt_r];
        end else begin
            lut_out_s   = bank0_r[pix1_r];
            copy_data_s = bank0_r[copy_cnt_r];
        end
    end

    // Next-state logic and the shadow write port (software writes in IDLE, copy-back in COPY).
    always_comb begin
        state_nxt_s   = state_r;
        swap_s        = 1'b0;
        shadow_we_s   = 1'b0;
        shadow_addr_s = IDX_ZERO;
        shadow_data_s = IDX_ZERO;
        case (state_r)
            ST_IDLE: begin
                if (cfg_wr_en) begin
                    shadow_we_s   = 1'b1;
                    shadow_addr_s = cfg_addr;
                    shadow_data_s = cfg_data;
                end else begin
                    shadow_we_s   = 1'b0;
                end
                if (cfg_commit) begin
                    state_nxt_s = ST_PENDING;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PENDING: begin
                // Swap either right after the last pixel of a picture has been
                // captured (it still uses the old bank), or when the stream is
                // completely quiet between pictures.
                if ((vld1_r && last1_r) || (!in_pic_r && !vld1_r && !valid_in)) begin
                    swap_s      = 1'b1;
                    state_nxt_s = ST_COPY;
                end else begin
                    state_nxt_s = ST_PENDING;
                end
            end
            ST_COPY: begin
                shadow_we_s   = 1'b1;
                shadow_addr_s = copy_cnt_r;
                shadow_data_s = copy_data_s;
                if (copy_cnt_r == IDX_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_COPY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control state: FSM, bank select, copy counter and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            bank_sel_r <= 1'b0;
            copy_cnt_r <= IDX_ZERO;
            cfg_busy   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cfg_busy   <= (state_nxt_s != ST_IDLE);
            if (swap_s) begin
                bank_sel_r <= ~bank_sel_r;
            end
            if (state_r == ST_COPY) begin
                copy_cnt_r <= copy_cnt_r + IDX_ONE;
            end else begin
                copy_cnt_r <= IDX_ZERO;
            end
        end
    end

    // LUT storage: both banks start as identity; writes always target the inactive bank.
    // bank_sel_r has already toggled during COPY, so the shadow is the old active bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_SIZE; i++) begin
                bank0_r[i] <= COLOR_DEPTH'(i);
                bank1_r[i] <= COLOR_DEPTH'(i);
            end
        end else if (shadow_we_s) begin
            if (bank_sel_r) begin
                bank0_r[shadow_addr_s] <= shadow_data_s;
            end else begin
                bank1_r[shadow_addr_s] <= shadow_data_s;
            end
        end
    end

    // Picture tracking.
    // A new non-last pixel opens a picture; that takes priority over closing
    // the previous one in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_pic_r <= 1'b0;
        end else if (valid_in && !last_pic_in) begin
            in_pic_r <= 1'b1;
        end else if (vld1_r && last1_r) begin
            in_pic_r <= 1'b0;
        end
    end

    // Two-stage datapath: capture inputs, then look up and register outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix1_r       <= IDX_ZERO;
            vld1_r       <= 1'b0;
            col1_r       <= {COLOR_BITS{1'b0}};
            last1_r      <= 1'b0;
            pixel_out    <= IDX_ZERO;
            valid_out    <= 1'b0;
            color_out    <= {COLOR_BITS{1'b0}};
            last_pic_out <= 1'b0;
        end else begin
            pix1_r       <= pixel_in;
            vld1_r       <= valid_in;
            col1_r       <= color_in;
            last1_r      <= last_pic_in;
            pixel_out    <= lut_out_s;
            valid_out    <= vld1_r;
            color_out    <= col1_r;
            last_pic_out <= last1_r;
        end
    end

endmodule

// File: tb/tb_degamma_lut.sv
module tb_degamma_lut;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pixel_in;
    logic       valid_in;
    logic [1:0] color_in;
    logic       last_pic_in;
    logic       cfg_wr_en;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_commit;
    logic       cfg_busy;
    logic [7:0] pixel_out;
    logic       valid_out;
    logic [1:0] color_out;
    logic       last_pic_out;

    always #5 clk = ~clk;

    degamma_lut #(.COLOR_DEPTH(8), .COLOR_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .pixel_in(pixel_in), .valid_in(valid_in), .color_in(color_in), .last_pic_in(last_pic_in),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .cfg_busy(cfg_busy),
        .pixel_out(pixel_out), .valid_out(valid_out), .color_out(color_out), .last_pic_out(last_pic_out)
    );

    typedef struct {
        logic       v;
        logic [7:0] pix;
        logic [1:0] col;
        logic       last;
    } exp_t;

    typedef struct {
        logic [7:0] pix;
        logic [1:0] col;
        logic       last;
        logic [7:0] exp_pix;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic last_busy = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_out(input exp_t e);
        n_tests++;
        if (valid_out !== e.v || color_out !== e.col || last_pic_out !== e.last ||
            (e.v && pixel_out !== e.pix)) begin
            n_fail++;
            $display("FAIL stream @%0t: got v=%0b pix=%0d col=%0d last=%0b, expected v=%0b pix=%0d col=%0d last=%0b",
                     $time, valid_out, pixel_out, color_out, last_pic_out, e.v, e.pix, e.col, e.last);
        end
    endtask

    // One clock of stimulus. Outputs seen at this negedge belong to the entry
    // pushed two steps earlier.
    task automatic step(input logic v, input logic [7:0] pix, input logic [1:0] col,
                        input logic last, input logic [7:0] exp_pix,
                        input logic we = 1'b0, input logic [7:0] addr = 8'd0,
                        input logic [7:0] data = 8'd0, input logic commit = 1'b0);
        exp_t e;
        @(negedge clk);
        last_busy = cfg_busy;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            check_out(e);
        end
        valid_in    = v;
        pixel_in    = pix;
        color_in    = col;
        last_pic_in = last;
        cfg_wr_en   = we;
        cfg_addr    = addr;
        cfg_data    = data;
        cfg_commit  = commit;
        e.v = v; e.pix = exp_pix; e.col = col; e.last = last;
        sb.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 8'd0, 2'd0, 1'b0, 8'd0);
    endtask

    task automatic drain();
        idle();
        idle();
    endtask

    task automatic wait_not_busy(input string name);
        int n;
        n = 0;
        while (last_busy && n < 400) begin
            idle();
            n++;
        end
        if (last_busy) begin
            chk(name, 1, 0);
        end
    endtask

    task automatic run_vecs(input vec_t tv[]);
        for (int i = 0; i < tv.size(); i++) begin
            step(1'b1, tv[i].pix, tv[i].col, tv[i].last, tv[i].exp_pix);
        end
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t t1[];
        vec_t t2[];
        vec_t t4[];
        vec_t t5[];
        int   n;

        t1 = new[4];
        t1[0] = '{8'd0,   2'd0, 1'b0, 8'd0};
        t1[1] = '{8'd1,   2'd1, 1'b0, 8'd1};
        t1[2] = '{8'd128, 2'd2, 1'b0, 8'd128};
        t1[3] = '{8'd255, 2'd3, 1'b1, 8'd255};
        t2 = new[4];
        t2[0] = '{8'd128, 2'd1, 1'b0, 8'd55};
        t2[1] = '{8'd1,   2'd2, 1'b0, 8'd0};
        t2[2] = '{8'd200, 2'd3, 1'b0, 8'd200};
        t2[3] = '{8'd0,   2'd0, 1'b1, 8'd0};
        t4 = new[3];
        t4[0] = '{8'd5,   2'd0, 1'b0, 8'd33};
        t4[1] = '{8'd128, 2'd1, 1'b0, 8'd77};
        t4[2] = '{8'd1,   2'd2, 1'b1, 8'd0};
        t5 = new[3];
        t5[0] = '{8'd128, 2'd3, 1'b0, 8'd128};
        t5[1] = '{8'd5,   2'd2, 1'b0, 8'd5};
        t5[2] = '{8'd1,   2'd1, 1'b1, 8'd1};

        rst_n = 1'b0;
        pixel_in = 8'd0; valid_in = 1'b0; color_in = 2'd0; last_pic_in = 1'b0;
        cfg_wr_en = 1'b0; cfg_addr = 8'd0; cfg_data = 8'd0; cfg_commit = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pixel_out", pixel_out, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_color_out", color_out, 0);
        chk("rst_last_out", last_pic_out, 0);
        chk("rst_busy", cfg_busy, 0);
        rst_n = 1'b1;

        // 1: identity after reset
        run_vecs(t1);

        // 2: idle commit, busy length, new mapping
        step(1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b1, 8'd1, 8'd0);
        step(1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b1, 8'd128, 8'd55);
        step(1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            idle();
            if (last_busy) n++;
            else if (n > 0) break;
        end
        chk("busy_len", n, 257);
        run_vecs(t2);

        // 3: commit mid-picture; swap lands at the picture boundary
        step(1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b1, 8'd128, 8'd77);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'd128, 2'(i % 4), (i == 99), 8'd55, 1'b0, 8'd0, 8'd0, (i == 20));
        end
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(1'b1, 8'd128, 2'(i % 4), (i == 5), 8'd77);
            else            step(1'b1, 8'd1,   2'(i % 4), (i == 5), 8'd0);
        end
        idle();
        wait_not_busy("busy_timeout_t3");
        drain();

        // 4: write and commit during COPY are ignored
        step(1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b1, 8'd5, 8'd33);
        step(1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1);
        for (int i = 0; i < 10; i++) idle();
        step(1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b1, 8'd5, 8'd9, 1'b1);
        idle();
        wait_not_busy("busy_timeout_t4");
        n = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (last_busy) n++;
        end
        chk("busy_after_dropped_commit", n, 0);
        run_vecs(t4);
        // a fresh commit with no edits must keep 5 -> 33 (the dropped write never reached the shadow)
        step(1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1);
        idle();
        wait_not_busy("busy_timeout_t4b");
        run_vecs(t4);

        // 5: reset in the middle of COPY
        step(1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b1, 8'd128, 8'd200);
        step(1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1);
        for (int i = 0; i < 96; i++) idle();
        for (int i = 0; i < 4; i++) step(1'b1, 8'd200, 2'd3, 1'b0, 8'd200);
        #2;
        rst_n = 1'b0;
        valid_in = 1'b0; pixel_in = 8'd0; color_in = 2'd0; last_pic_in = 1'b0;
        cfg_wr_en = 1'b0; cfg_commit = 1'b0;
        #1;
        chk("midcopy_rst_pixel_out", pixel_out, 0);
        chk("midcopy_rst_valid_out", valid_out, 0);
        chk("midcopy_rst_color_out", color_out, 0);
        chk("midcopy_rst_busy", cfg_busy, 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (last_busy) n++;
        end
        chk("busy_after_rst", n, 0);
        run_vecs(t5);

        // 6: 1-of-3 valid duty across a swap
        step(1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b1, 8'd10, 8'd99);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'd10, 2'(i % 4), (i == 11), 8'd10, 1'b0, 8'd0, 8'd0, (i == 3));
            idle();
            idle();
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'd10, 2'(i % 4), (i == 5), 8'd99);
            idle();
            idle();
        end
        wait_not_busy("busy_timeout_t6");
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
